result_transpose_stager: RTL

- Downstream stage of the matrix-multiply engine.
- Reads a row-major matrix (e.g. K) from the result SRAM and writes its transpose into the scratchpad SRAM, so the attention-score stage can stream K^T rows sequentially.
- Pure data mover with a start/ready handshake; no arithmetic on element data.
- Matrix dimensions and base addresses are supplied by the top-level sequencer.

---
 rtl/result_transpose_stager_if.sv | 34 +++
 rtl/result_transpose_stager.sv | 115 +++++++++++
 2 files changed

// File: rtl/result_transpose_stager_if.sv
// Control handshake and SRAM-side bus of the result transpose stager.
// The sequencer/memory side uses the master modport, the stager uses slave.
interface result_transpose_stager_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
);
  logic              start;
  logic              ready;
  logic              done;
  logic [DIM_W-1:0]  rows;
  logic [DIM_W-1:0]  cols;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] dut__tb__sram_result_read_address;
  logic [DATA_W-1:0] tb__dut__sram_result_read_data;
  logic              dut__tb__sram_scratchpad_write_enable;
  logic [ADDR_W-1:0] dut__tb__sram_scratchpad_write_address;
  logic [DATA_W-1:0] dut__tb__sram_scratchpad_write_data;

  modport master (
    output start, rows, cols, src_base, dst_base, tb__dut__sram_result_read_data,
    input  ready, done, dut__tb__sram_result_read_address,
           dut__tb__sram_scratchpad_write_enable, dut__tb__sram_scratchpad_write_address,
           dut__tb__sram_scratchpad_write_data
  );

  modport slave (
    input  start, rows, cols, src_base, dst_base, tb__dut__sram_result_read_data,
    output ready, done, dut__tb__sram_result_read_address,
           dut__tb__sram_scratchpad_write_enable, dut__tb__sram_scratchpad_write_address,
           dut__tb__sram_scratchpad_write_data
  );
endinterface

// File: rtl/result_transpose_stager.sv
// Streams a row-major matrix out of the result SRAM, one element per cycle,
// and writes its transpose into the scratchpad SRAM.
module result_transpose_stager #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  result_transpose_stager_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic              ready_q;
  logic              done_q;
  logic [DIM_W-1:0]  rows_q;
  logic [DIM_W-1:0]  cols_q;
  logic [DIM_W-1:0]  r_cnt;
  logic [DIM_W-1:0]  c_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] dst_row;
  logic              wr_vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_data_hold;
  logic              last_col;
  logic              last_row;

  assign last_col = (c_cnt == cols_q - DIM_W'(1));
  assign last_row = (r_cnt == rows_q - DIM_W'(1));

  assign bus.ready                                  = ready_q;
  assign bus.done                                   = done_q;
  assign bus.dut__tb__sram_result_read_address      = rd_addr;
  assign bus.dut__tb__sram_scratchpad_write_enable  = wr_vld_p1;
  assign bus.dut__tb__sram_scratchpad_write_address = wr_addr_p1;
  // Read data arrives in the write cycle itself; the hold register keeps the
  // data port stable between strobes.
  assign bus.dut__tb__sram_scratchpad_write_data    = wr_vld_p1 ? bus.tb__dut__sram_result_read_data
                                                                : wr_data_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      rows_q       <= '0;
      cols_q       <= '0;
      r_cnt        <= '0;
      c_cnt        <= '0;
      rd_addr      <= '0;
      dst_ptr      <= '0;
      dst_row      <= '0;
      wr_vld_p1    <= 1'b0;
      wr_addr_p1   <= '0;
      wr_data_hold <= '0;
    end else begin
      done_q    <= 1'b0;
      wr_vld_p1 <= 1'b0;
      if (wr_vld_p1) wr_data_hold <= bus.tb__dut__sram_result_read_data;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rows_q  <= bus.rows;
            cols_q  <= bus.cols;
            r_cnt   <= '0;
            c_cnt   <= '0;
            ready_q <= 1'b0;
            if (bus.rows == '0 || bus.cols == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= READ;
              rd_addr <= bus.src_base;
              dst_ptr <= bus.dst_base;
              dst_row <= bus.dst_base;
            end
          end
        end
        // Issue stage: element at rd_addr is read now, written next cycle to dst_ptr.
        READ: begin
          wr_vld_p1  <= 1'b1;
          wr_addr_p1 <= dst_ptr;
          if (last_row && last_col) begin
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (last_col) begin
              c_cnt   <= '0;
              r_cnt   <= r_cnt + DIM_W'(1);
              dst_row <= dst_row + ADDR_W'(1);
              dst_ptr <= dst_row + ADDR_W'(1);
            end else begin
              c_cnt   <= c_cnt + DIM_W'(1);
              dst_ptr <= dst_ptr + ADDR_W'(rows_q);
            end
          end
        end
        // Write stage for the final element is in flight during DRAIN.
        DRAIN: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
